// File: rtl/phy_tx_arbiter_pkg.sv
// Shared definitions for the PHY transmit arbiter: state encoding and word format.
package phy_tx_arbiter_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StSend  = 2'd1,
        StGap   = 2'd2,
        StDrain = 2'd3
    } tx_state_e;

    localparam logic [8:0]  TermWord      = 9'h000;
    localparam int unsigned DataBit       = 8;
    localparam int unsigned DefaultMaxLen = 1518;

endpackage

// File: rtl/phy_tx_arbiter.sv
// Frame-granular round-robin arbiter sharing the PHY transmit FIFO between two sources,
// with length enforcement, inter-frame gap insertion and status counters.
module phy_tx_arbiter
    import phy_tx_arbiter_pkg::*;
#(
    parameter int unsigned MAX_LEN   = DefaultMaxLen,
    parameter int unsigned GAP_WORDS = 2
) (
    input  logic        pcie_clk,
    input  logic        sys_rst,
    input  logic [8:0]  req0_dout,
    input  logic        req0_empty,
    input  logic        req0_frame_avail,
    output logic        req0_rd_en,
    input  logic [8:0]  req1_dout,
    input  logic        req1_empty,
    input  logic        req1_frame_avail,
    output logic        req1_rd_en,
    output logic [8:0]  phy_din,
    input  logic        phy_full,
    output logic        phy_wr_en,
    output logic [1:0]  grant,
    output logic [15:0] frame_cnt,
    output logic [7:0]  trunc_cnt
);

    localparam logic [11:0] MaxLen  = 12'(MAX_LEN);
    localparam logic [3:0]  GapLast = 4'(GAP_WORDS - 1);

    // last: 1 means req1 was granted most recently, so req0 wins a tie.
    function automatic logic [1:0] rr_pick(input logic [1:0] avail, input logic last);
        unique case (avail)
            2'b01:   return 2'b01;
            2'b10:   return 2'b10;
            2'b11:   return last ? 2'b01 : 2'b10;
            default: return 2'b00;
        endcase
    endfunction

    tx_state_e   state_q, state_d;
    logic [1:0]  grant_q, grant_d;
    logic        last_grant_q, last_grant_d;
    logic [11:0] len_q, len_d;
    logic [3:0]  gap_cnt_q, gap_cnt_d;
    logic [8:0]  phy_din_q, phy_din_d;
    logic        phy_wr_en_q, phy_wr_en_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic [7:0]  trunc_cnt_q, trunc_cnt_d;
    logic [1:0]  pick;
    logic        pop;
    logic [8:0]  src_word;
    logic        src_empty;

    assign src_word  = grant_q[1] ? req1_dout  : req0_dout;
    assign src_empty = grant_q[1] ? req1_empty : req0_empty;

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        len_d        = len_q;
        gap_cnt_d    = gap_cnt_q;
        phy_din_d    = TermWord;
        phy_wr_en_d  = 1'b0;
        frame_cnt_d  = frame_cnt_q;
        trunc_cnt_d  = trunc_cnt_q;
        pick         = 2'b00;
        pop          = 1'b0;

        unique case (state_q)
            StIdle: begin
                pick = rr_pick({req1_frame_avail, req0_frame_avail}, last_grant_q);
                if (pick != 2'b00) begin
                    grant_d      = pick;
                    last_grant_d = pick[1];
                    state_d      = StSend;
                end
            end
            StSend: begin
                if (!src_empty && !phy_full) begin
                    phy_wr_en_d = 1'b1;
                    if (src_word[DataBit] && len_q == MaxLen) begin
                        // Over-long frame: close it here and discard the rest in DRAIN.
                        frame_cnt_d = frame_cnt_q + 16'd1;
                        trunc_cnt_d = (trunc_cnt_q == 8'hFF) ? trunc_cnt_q : trunc_cnt_q + 8'd1;
                        state_d     = StDrain;
                    end else if (src_word[DataBit]) begin
                        pop       = 1'b1;
                        phy_din_d = src_word;
                        len_d     = len_q + 12'd1;
                    end else begin
                        pop         = 1'b1;
                        frame_cnt_d = frame_cnt_q + 16'd1;
                        len_d       = '0;
                        if (GAP_WORDS > 0) begin
                            state_d = StGap;
                        end else begin
                            state_d = StIdle;
                            grant_d = 2'b00;
                        end
                    end
                end
            end
            StDrain: begin
                if (!src_empty) begin
                    pop = 1'b1;
                    if (!src_word[DataBit]) begin
                        len_d = '0;
                        if (GAP_WORDS > 0) begin
                            state_d = StGap;
                        end else begin
                            state_d = StIdle;
                            grant_d = 2'b00;
                        end
                    end
                end
            end
            StGap: begin
                if (!phy_full) begin
                    phy_wr_en_d = 1'b1;
                    if (gap_cnt_q == GapLast) begin
                        gap_cnt_d = '0;
                        state_d   = StIdle;
                        grant_d   = 2'b00;
                        len_d     = '0;
                    end else begin
                        gap_cnt_d = gap_cnt_q + 4'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge pcie_clk) begin
        if (sys_rst) begin
            state_q      <= StIdle;
            grant_q      <= 2'b00;
            last_grant_q <= 1'b1;
            len_q        <= '0;
            gap_cnt_q    <= '0;
            phy_din_q    <= TermWord;
            phy_wr_en_q  <= 1'b0;
            frame_cnt_q  <= '0;
            trunc_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            len_q        <= len_d;
            gap_cnt_q    <= gap_cnt_d;
            phy_din_q    <= phy_din_d;
            phy_wr_en_q  <= phy_wr_en_d;
            frame_cnt_q  <= frame_cnt_d;
            trunc_cnt_q  <= trunc_cnt_d;
        end
    end

    assign req0_rd_en = pop & grant_q[0];
    assign req1_rd_en = pop & grant_q[1];
    assign phy_din    = phy_din_q;
    assign phy_wr_en  = phy_wr_en_q;
    assign grant      = grant_q;
    assign frame_cnt  = frame_cnt_q;
    assign trunc_cnt  = trunc_cnt_q;

endmodule

// File: tb/tb_phy_tx_arbiter.sv
// Self-checking bench for phy_tx_arbiter: FWFT source models, a PHY FIFO monitor and a
// frame-level reference model that predicts the exact PHY word stream.
module tb_phy_tx_arbiter;

    localparam int unsigned MaxLen   = 100;
    localparam int unsigned GapWords = 2;
    localparam int          PhyDepth = 6;

    logic        pcie_clk = 1'b0;
    logic        sys_rst;
    logic [8:0]  req0_dout, req1_dout;
    logic        req0_empty, req1_empty;
    logic        req0_frame_avail, req1_frame_avail;
    logic        req0_rd_en, req1_rd_en;
    logic [8:0]  phy_din;
    logic        phy_full;
    logic        phy_wr_en;
    logic [1:0]  grant;
    logic [15:0] frame_cnt;
    logic [7:0]  trunc_cnt;

    always #5 pcie_clk = ~pcie_clk;

    phy_tx_arbiter #(
        .MAX_LEN   (MaxLen),
        .GAP_WORDS (GapWords)
    ) dut (
        .pcie_clk         (pcie_clk),
        .sys_rst          (sys_rst),
        .req0_dout        (req0_dout),
        .req0_empty       (req0_empty),
        .req0_frame_avail (req0_frame_avail),
        .req0_rd_en       (req0_rd_en),
        .req1_dout        (req1_dout),
        .req1_empty       (req1_empty),
        .req1_frame_avail (req1_frame_avail),
        .req1_rd_en       (req1_rd_en),
        .phy_din          (phy_din),
        .phy_full         (phy_full),
        .phy_wr_en        (phy_wr_en),
        .grant            (grant),
        .frame_cnt        (frame_cnt),
        .trunc_cnt        (trunc_cnt)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Pops are taken at the clock edge and applied to the source queues at the next negedge.
    logic [1:0] pop_pending = 2'b00;
    always @(posedge pcie_clk) pop_pending <= {req1_rd_en, req0_rd_en};

    logic [8:0] src0[$], src1[$];
    int         term0, term1, pops1;
    int         stall_lim = -1;

    logic [8:0] got_q[$], exp_q[$];
    int         got_cyc[$];
    bit         bp_mode, prev_full;
    int         occ, viol, ovf;

    logic [8:0] m0[$], m1[$];
    int         ml0[$], ml1[$];
    bit         m_last;
    int         m_frames, m_trunc;

    task automatic drive_src();
        req0_empty       = (src0.size() == 0);
        req0_dout        = req0_empty ? 9'h000 : src0[0];
        req0_frame_avail = (term0 > 0);
        req1_empty       = (src1.size() == 0) || (stall_lim >= 0 && pops1 >= stall_lim);
        req1_dout        = (src1.size() == 0) ? 9'h000 : src1[0];
        req1_frame_avail = (term1 > 0);
    endtask

    task automatic tick();
        @(negedge pcie_clk);
        cyc++;
        if (phy_wr_en) begin
            got_q.push_back(phy_din);
            got_cyc.push_back(cyc);
        end
        if (bp_mode) begin
            if (phy_wr_en && prev_full) viol++;
            if (phy_wr_en) occ++;
            if (occ > PhyDepth) ovf++;
            if (cyc % 2 == 0 && occ > 0) occ--;
        end
        if (pop_pending[0] && src0.size() > 0) begin
            if (!src0[0][8]) term0--;
            void'(src0.pop_front());
        end
        if (pop_pending[1] && src1.size() > 0) begin
            if (!src1[0][8]) term1--;
            void'(src1.pop_front());
            pops1++;
        end
        phy_full  = bp_mode && (((cyc / 3) % 2 == 1) || occ >= PhyDepth - 2);
        prev_full = phy_full;
        drive_src();
    endtask

    task automatic clear_tb();
        src0.delete(); src1.delete(); got_q.delete(); got_cyc.delete(); exp_q.delete();
        m0.delete(); m1.delete(); ml0.delete(); ml1.delete();
        term0 = 0; term1 = 0; pops1 = 0; stall_lim = -1;
        m_last = 1'b1; m_frames = 0; m_trunc = 0;
        bp_mode = 1'b0; prev_full = 1'b0; occ = 0; viol = 0; ovf = 0;
        phy_full = 1'b0;
        drive_src();
    endtask

    task automatic do_reset();
        sys_rst = 1'b1;
        tick();
        tick();
        clear_tb();
        sys_rst = 1'b0;
    endtask

    // fixed = 1 uses the per-source marker word instead of random data.
    task automatic add_frame(input int src, input int len, input bit fixed);
        logic [8:0] w;
        for (int i = 0; i < len; i++) begin
            w = fixed ? ((src == 0) ? 9'h1AA : 9'h155) : {1'b1, 8'($urandom)};
            if (src == 0) begin src0.push_back(w); m0.push_back(w); end
            else          begin src1.push_back(w); m1.push_back(w); end
        end
        if (src == 0) begin src0.push_back(9'h000); term0++; ml0.push_back(len); end
        else          begin src1.push_back(9'h000); term1++; ml1.push_back(len); end
        drive_src();
    endtask

    // Frame-level prediction: alternate on ties, cap at MaxLen, then terminator and gap.
    task automatic model_run();
        while (ml0.size() > 0 || ml1.size() > 0) begin
            int         s;
            int         len;
            logic [8:0] w;
            if (ml0.size() > 0 && ml1.size() > 0) s = m_last ? 0 : 1;
            else                                  s = (ml0.size() > 0) ? 0 : 1;
            m_last = (s == 1);
            len = (s == 0) ? ml0.pop_front() : ml1.pop_front();
            for (int i = 0; i < len; i++) begin
                w = (s == 0) ? m0.pop_front() : m1.pop_front();
                if (i < int'(MaxLen)) exp_q.push_back(w);
            end
            exp_q.push_back(9'h000);
            for (int g = 0; g < int'(GapWords); g++) exp_q.push_back(9'h000);
            m_frames++;
            if (len > int'(MaxLen)) m_trunc++;
        end
    endtask

    function automatic int stream_diff();
        int n;
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) if (got_q[i] !== exp_q[i]) return i;
        if (got_q.size() != exp_q.size()) return n;
        return -1;
    endfunction

    task automatic run_frames(input int budget, output bit timed_out);
        int n;
        n = 0;
        timed_out = 1'b0;
        while (!(got_q.size() >= exp_q.size() && grant == 2'b00 &&
                 src0.size() == 0 && src1.size() == 0)) begin
            tick();
            n++;
            if (n >= budget) begin
                timed_out = 1'b1;
                break;
            end
        end
        repeat (4) tick();
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (phy_wr_en !== 1'b0) begin
            errors++; $display("FAIL reset_wr_en got %b want 0", phy_wr_en);
        end
        checks++;
        if (phy_din !== 9'h000) begin
            errors++; $display("FAIL reset_din got %h want 000", phy_din);
        end
        checks++;
        if (grant !== 2'b00) begin
            errors++; $display("FAIL reset_grant got %b want 00", grant);
        end
        checks++;
        if ({req1_rd_en, req0_rd_en} !== 2'b00) begin
            errors++; $display("FAIL reset_rd_en got %b want 00", {req1_rd_en, req0_rd_en});
        end
        checks++;
        if (frame_cnt !== 16'd0 || trunc_cnt !== 8'd0) begin
            errors++; $display("FAIL reset_counters got %0d/%0d want 0/0", frame_cnt, trunc_cnt);
        end
    endtask

    task automatic test_single();
        int t, d;
        bit to, seq_ok;
        do_reset();
        add_frame(0, 60, 1'b0);
        model_run();
        t = cyc;
        tick();
        checks++;
        if (grant !== 2'b01 || {req1_rd_en, req0_rd_en} !== 2'b01) begin
            errors++;
            $display("FAIL single_grant got grant %b rd %b want 01/01", grant,
                     {req1_rd_en, req0_rd_en});
        end
        run_frames(500, to);
        checks++;
        if (to) begin errors++; $display("FAIL single_timeout got timeout want done"); end
        d = stream_diff();
        checks++;
        if (d != -1) begin
            errors++;
            $display("FAIL single_stream idx %0d got %h want %h (%0d vs %0d words)", d, got_q[d],
                     exp_q[d], got_q.size(), exp_q.size());
        end
        seq_ok = (got_cyc.size() == 63);
        for (int i = 0; i < got_cyc.size(); i++) if (got_cyc[i] != t + 2 + i) seq_ok = 1'b0;
        checks++;
        if (!seq_ok) begin
            errors++;
            $display("FAIL single_timing got first write cycle %0d (%0d writes) want %0d (63)",
                     (got_cyc.size() > 0) ? got_cyc[0] - t : -1, got_cyc.size(), 2);
        end
        checks++;
        if (frame_cnt !== 16'd1 || grant !== 2'b00) begin
            errors++;
            $display("FAIL single_end got frame_cnt %0d grant %b want 1/00", frame_cnt, grant);
        end
    endtask

    task automatic test_contention();
        int d;
        bit to;
        do_reset();
        for (int k = 0; k < 3; k++) begin
            add_frame(0, int'($urandom_range(1, 40)), 1'b1);
            add_frame(1, int'($urandom_range(1, 40)), 1'b1);
        end
        model_run();
        run_frames(2000, to);
        checks++;
        if (to) begin errors++; $display("FAIL contention_timeout got timeout want done"); end
        d = stream_diff();
        checks++;
        if (d != -1) begin
            errors++;
            $display("FAIL contention_stream idx %0d got %h want %h (%0d vs %0d words)", d,
                     got_q[d], exp_q[d], got_q.size(), exp_q.size());
        end
        checks++;
        if (got_q.size() == 0 || got_q[0] !== 9'h1AA) begin
            errors++;
            $display("FAIL contention_first_tie got %h want 1aa",
                     (got_q.size() > 0) ? got_q[0] : 9'h000);
        end
        checks++;
        if (frame_cnt !== 16'd6) begin
            errors++; $display("FAIL contention_frame_cnt got %0d want 6", frame_cnt);
        end
    endtask

    task automatic test_back_pressure();
        int d;
        bit to;
        do_reset();
        bp_mode = 1'b1;
        add_frame(0, int'(MaxLen), 1'b0);
        model_run();
        run_frames(3000, to);
        bp_mode  = 1'b0;
        phy_full = 1'b0;
        checks++;
        if (to) begin errors++; $display("FAIL bp_timeout got timeout want done"); end
        d = stream_diff();
        checks++;
        if (d != -1) begin
            errors++;
            $display("FAIL bp_stream idx %0d got %h want %h (%0d vs %0d words)", d, got_q[d],
                     exp_q[d], got_q.size(), exp_q.size());
        end
        checks++;
        if (viol != 0 || ovf != 0) begin
            errors++;
            $display("FAIL bp_full_respect got %0d late writes %0d overflows want 0/0", viol, ovf);
        end
        checks++;
        if (trunc_cnt !== 8'd0 || frame_cnt !== 16'd1) begin
            errors++;
            $display("FAIL bp_counters got %0d/%0d want 1/0", frame_cnt, trunc_cnt);
        end
    endtask

    task automatic test_truncation();
        int d;
        bit to;
        do_reset();
        add_frame(0, int'(MaxLen) + 4, 1'b0);
        add_frame(int'($urandom_range(0, 1)), 10, 1'b0);
        add_frame(1, 0, 1'b0);
        model_run();
        run_frames(2000, to);
        checks++;
        if (to) begin errors++; $display("FAIL trunc_timeout got timeout want done"); end
        d = stream_diff();
        checks++;
        if (d != -1) begin
            errors++;
            $display("FAIL trunc_stream idx %0d got %h want %h (%0d vs %0d words)", d, got_q[d],
                     exp_q[d], got_q.size(), exp_q.size());
        end
        checks++;
        if (trunc_cnt !== 8'd1 || frame_cnt !== 16'd3) begin
            errors++;
            $display("FAIL trunc_counters got %0d/%0d want 3/1", frame_cnt, trunc_cnt);
        end
        checks++;
        if (src0.size() != 0 || src1.size() != 0) begin
            errors++;
            $display("FAIL trunc_drained got %0d/%0d left want 0/0", src0.size(), src1.size());
        end
    endtask

    task automatic test_stall_reset();
        int d, n;
        bit to;
        do_reset();
        stall_lim = 10;
        add_frame(1, 25, 1'b0);
        model_run();
        n = 0;
        while (got_q.size() < 10 && n < 200) begin tick(); n++; end
        repeat (20) tick();
        checks++;
        if (got_q.size() != 10 || grant !== 2'b10) begin
            errors++;
            $display("FAIL stall_hold got %0d writes grant %b want 10 writes grant 10",
                     got_q.size(), grant);
        end
        stall_lim = -1;
        drive_src();
        run_frames(500, to);
        d = stream_diff();
        checks++;
        if (to || d != -1) begin
            errors++;
            $display("FAIL stall_resume got idx %0d timeout %0d want -1/0", d, to);
        end

        add_frame(0, 50, 1'b0);
        repeat (20) tick();
        sys_rst = 1'b1;
        tick();
        checks++;
        if (phy_wr_en !== 1'b0 || phy_din !== 9'h000 || grant !== 2'b00 ||
            {req1_rd_en, req0_rd_en} !== 2'b00 || frame_cnt !== 16'd0 || trunc_cnt !== 8'd0) begin
            errors++;
            $display("FAIL midreset_outputs got wr %b din %h grant %b rd %b cnt %0d/%0d want 0",
                     phy_wr_en, phy_din, grant, {req1_rd_en, req0_rd_en}, frame_cnt, trunc_cnt);
        end
        clear_tb();
        sys_rst = 1'b0;
        add_frame(0, 5, 1'b0);
        model_run();
        run_frames(200, to);
        d = stream_diff();
        checks++;
        if (to || d != -1 || frame_cnt !== 16'd1) begin
            errors++;
            $display("FAIL midreset_restart got idx %0d timeout %0d frame_cnt %0d want -1/0/1",
                     d, to, frame_cnt);
        end
    endtask

    task automatic test_counters();
        int d, exp_trunc;
        bit to;
        do_reset();
        for (int k = 0; k < 300; k++)
            add_frame(int'($urandom_range(0, 1)), int'(MaxLen + $urandom_range(1, 3)), 1'b0);
        model_run();
        run_frames(60000, to);
        checks++;
        if (to) begin errors++; $display("FAIL counters_timeout got timeout want done"); end
        d = stream_diff();
        checks++;
        if (d != -1) begin
            errors++;
            $display("FAIL counters_stream idx %0d got %h want %h (%0d vs %0d words)", d,
                     got_q[d], exp_q[d], got_q.size(), exp_q.size());
        end
        exp_trunc = (m_trunc > 255) ? 255 : m_trunc;
        checks++;
        if (int'(trunc_cnt) != exp_trunc) begin
            errors++; $display("FAIL counters_trunc got %0d want %0d", trunc_cnt, exp_trunc);
        end
        checks++;
        if (int'(frame_cnt) != m_frames) begin
            errors++; $display("FAIL counters_frame got %0d want %0d", frame_cnt, m_frames);
        end
    endtask

    initial begin
        sys_rst = 1'b1;
        clear_tb();
        test_reset();
        test_single();
        test_contention();
        test_back_pressure();
        test_truncation();
        test_stall_reset();
        test_counters();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
